uart_tx_fifo: RTL and testbench

Parametrised UART transmitter that generalises the fixed 8N1 serializer. Frame shape is configurable: data width set by parameter, parity and stop-bit count selectable at run time. A valid/ready input handshake feeds a small word FIFO, so back-to-back frames go out with no idle gap. The block sits between the system-side producer (bus or command logic) and the board TX pin.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_fifo.sv | 64 ++++++
 rtl/uart_tx_fifo.sv | 157 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART transmitter.
// Holds the serializer state encoding, the parity selector and the baud divisor.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_e;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous word FIFO with registered occupancy count.
// Push while full and pop while empty are ignored; pointers wrap modulo DEPTH.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: storage carries no reset; only the pointers and count define validity,
  // which keeps the array as plain RAM-style flops without a reset tree.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // NOTE: state updates use non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with configurable frame (data width, parity, stop bits)
// fed by a valid/ready word FIFO so queued frames go out back to back.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 25_000_000,
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_BITS-1:0]     data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               parity_mode,
  input  logic                     two_stop,
  output logic                     tx,
  output logic                     tx_done,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int CPB    = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int BAUD_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CPB - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  if (CPB < 1) begin : g_bad_baud
    $error("uart_tx_fifo: CLK_FREQ / BAUD_RATE must be at least 1");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
    $error("uart_tx_fifo: DATA_BITS must be in 5..9");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of 2 and at least 2");
  end

  state_e                 state;
  logic [BAUD_W-1:0]      baud_cnt;
  logic [BIT_W-1:0]       bit_cnt;
  logic [DATA_BITS-1:0]   shift;
  logic [DATA_BITS-1:0]   fifo_rdata;
  logic                   par_en;
  logic                   par_bit;
  logic                   two_stop_q;
  logic                   stop_second;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   push;
  logic                   pop;
  logic                   baud_last;
  logic                   stop_end;

  // in_ready comes straight from the registered count, never from this cycle's pop.
  assign in_ready  = ~fifo_full;
  assign push      = in_valid & in_ready;
  assign baud_last = (baud_cnt == BAUD_LAST);
  assign stop_end  = (state == STOP) && baud_last && (!two_stop_q || stop_second);
  assign pop       = ~fifo_empty && ((state == IDLE) || stop_end);

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      par_en      <= 1'b0;
      par_bit     <= 1'b0;
      two_stop_q  <= 1'b0;
      stop_second <= 1'b0;
      tx          <= 1'b1;
      tx_done     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      tx_done <= 1'b0;

      if (state == IDLE || baud_last) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + BAUD_W'(1);
      end

      case (state)
        IDLE: begin
        end
        START: begin
          if (baud_last) begin
            state   <= DATA;
            tx      <= shift[0];
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (baud_last) begin
            if (bit_cnt == BIT_LAST) begin
              state <= par_en ? PARITY : STOP;
              tx    <= par_en ? par_bit : 1'b1;
            end else begin
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end
        PARITY: begin
          if (baud_last) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
        STOP: begin
          if (baud_last) begin
            if (two_stop_q && !stop_second) begin
              stop_second <= 1'b1;
            end else begin
              tx_done <= 1'b1;
              state   <= IDLE;
              busy    <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // A pop loads the next frame and overrides the STOP->IDLE return above,
      // so queued words follow the stop bit with no idle cycle.
      if (pop) begin
        state       <= START;
        tx          <= 1'b0;
        busy        <= 1'b1;
        shift       <= fifo_rdata;
        par_en      <= (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
        par_bit     <= (^fifo_rdata) ^ (parity_mode == PAR_ODD);
        two_stop_q  <= two_stop;
        stop_second <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed frame scenarios plus random
// traffic, compared against a queue-based waveform model of the line.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int CPB   = 2;
  localparam int DBITS = 8;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic [7:0] data;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] parity_mode;
  logic       two_stop;
  logic       tx;
  logic       tx_done;
  logic       busy;
  logic [2:0] fifo_count;

  uart_tx_fifo #(
    .CLK_FREQ  (50_000_000),
    .BAUD_RATE (25_000_000),
    .DATA_BITS (DBITS),
    .DEPTH     (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data        (data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .tx          (tx),
    .tx_done     (tx_done),
    .busy        (busy),
    .fifo_count  (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: words waiting in the FIFO, and the remaining per-cycle
  // line levels of the frame currently on the wire.
  logic [7:0] m_q[$];
  logic       m_bits[$];
  logic       m_done;

  function automatic void build_frame(input logic [7:0] w, input logic [1:0] pm, input logic ts);
    logic slots[$];
    slots.push_back(1'b0);
    for (int i = 0; i < DBITS; i++) slots.push_back(w[i]);
    if (pm == 2'b01) slots.push_back(^w);
    if (pm == 2'b10) slots.push_back(~(^w));
    slots.push_back(1'b1);
    if (ts) slots.push_back(1'b1);
    foreach (slots[i]) for (int k = 0; k < CPB; k++) m_bits.push_back(slots[i]);
  endfunction

  function automatic void model_step(input logic r, input logic v, input logic [7:0] d);
    logic acc;
    m_done = 1'b0;
    if (r) begin
      m_q.delete();
      m_bits.delete();
    end else begin
      acc = v && (m_q.size() != DEPTH);
      if (m_bits.size() != 0) begin
        void'(m_bits.pop_front());
        if (m_bits.size() == 0) m_done = 1'b1;
      end
      if (m_bits.size() == 0 && m_q.size() != 0) build_frame(m_q.pop_front(), parity_mode, two_stop);
      if (acc) m_q.push_back(d);
    end
  endfunction

  // Per-cycle record of DUT outputs for directed slot/timing checks.
  logic tr_tx[$];
  logic tr_done[$];
  logic tr_busy[$];

  task automatic clear_trace();
    tr_tx.delete();
    tr_done.delete();
    tr_busy.delete();
  endtask

  task automatic tick(input logic r, input logic v, input logic [7:0] d);
    rst      = r;
    in_valid = v;
    data     = d;
    @(posedge clk);
    model_step(r, v, d);
    #1;
    check($sformatf("tx@%0d", cyc), tx, (m_bits.size() != 0) ? m_bits[0] : 1'b1);
    check($sformatf("tx_done@%0d", cyc), tx_done, m_done);
    check($sformatf("busy@%0d", cyc), busy, m_bits.size() != 0);
    check($sformatf("in_ready@%0d", cyc), in_ready, m_q.size() != DEPTH);
    check($sformatf("fifo_count@%0d", cyc), fifo_count, m_q.size());
    check($sformatf("state_idle@%0d", cyc), dut.state == IDLE, m_bits.size() == 0);
    tr_tx.push_back(tx);
    tr_done.push_back(tx_done);
    tr_busy.push_back(busy);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'($urandom));
  endtask

  function automatic int find_first(input logic q[$], input logic val, input int from);
    for (int i = from; i < q.size(); i++) if (q[i] == val) return i;
    return -1;
  endfunction

  function automatic logic [15:0] slots_of(input int start, input int n);
    logic [15:0] s;
    s = '0;
    for (int i = 0; i < n; i++) begin
      int idx;
      idx = start + CPB * i;
      s[i] = (start >= 0 && idx < tr_tx.size()) ? tr_tx[idx] : 1'bx;
    end
    return s;
  endfunction

  function automatic int count_ones(input logic q[$]);
    int c;
    c = 0;
    foreach (q[i]) if (q[i] == 1'b1) c++;
    return c;
  endfunction

  initial begin
    int st, d1, d2, sent, b0, run;
    logic [7:0] wx, wy;

    rst = 1'b1; in_valid = 1'b0; data = '0; parity_mode = 2'b00; two_stop = 1'b0;

    // Reset state
    tick(1'b1, 1'b0, 8'h00);
    check("rst_tx", tx, 1'b1);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_count", fifo_count, 3'd0);
    check("rst_state", dut.state, IDLE);
    idle(2);

    // 8N1 frame of 0x55
    clear_trace();
    tick(1'b0, 1'b1, 8'h55);
    idle(25);
    st = find_first(tr_tx, 1'b0, 0);
    check("n1_latency", st, 1);
    check("n1_slots", slots_of(st, 10), 16'h02AA);
    d1 = find_first(tr_done, 1'b1, 0);
    check("n1_done_delay", d1 - st, 20);
    check("n1_done_count", count_ones(tr_done), 1);

    // Even parity, two stops, then odd parity
    parity_mode = 2'b01; two_stop = 1'b1;
    clear_trace();
    tick(1'b0, 1'b1, 8'h07);
    idle(30);
    st = find_first(tr_tx, 1'b0, 0);
    check("even_slots", slots_of(st, 12), 16'h0E0E);
    check("even_done_delay", find_first(tr_done, 1'b1, 0) - st, 24);
    parity_mode = 2'b10;
    clear_trace();
    tick(1'b0, 1'b1, 8'h07);
    idle(30);
    st = find_first(tr_tx, 1'b0, 0);
    check("odd_slots", slots_of(st, 12), 16'h0C0E);

    // Backpressure with contiguous frames
    parity_mode = 2'b00; two_stop = 1'b0;
    clear_trace();
    sent = 0;
    for (int i = 0; i < 20 && sent < 6; i++) begin
      if (!in_ready) break;
      tick(1'b0, 1'b1, 8'($urandom));
      sent++;
    end
    check("bp_accepted", sent, 5);
    idle(120);
    check("bp_done_count", count_ones(tr_done), 5);
    b0 = find_first(tr_busy, 1'b1, 0);
    run = 0;
    for (int i = (b0 < 0 ? tr_busy.size() : b0); i < tr_busy.size() && tr_busy[i]; i++) run++;
    check("bp_busy_run", run, 5 * 10 * CPB);

    // Reset during the third data bit with two words queued
    clear_trace();
    tick(1'b0, 1'b1, 8'($urandom));
    tick(1'b0, 1'b1, 8'($urandom));
    tick(1'b0, 1'b1, 8'($urandom));
    idle(5);
    check("mid_count_before", fifo_count, 3'd2);
    tick(1'b1, 1'b1, 8'hFF);
    check("mid_tx", tx, 1'b1);
    check("mid_state", dut.state, IDLE);
    check("mid_count", fifo_count, 3'd0);
    check("mid_done", tx_done, 1'b0);
    idle(1);
    clear_trace();
    tick(1'b0, 1'b1, 8'hA5);
    idle(25);
    st = find_first(tr_tx, 1'b0, 0);
    check("mid_a5_slots", slots_of(st, 10), 16'h034A);
    check("mid_a5_done", find_first(tr_done, 1'b1, 0) - st, 20);

    // Configuration changes after the pop do not touch the frame in flight
    clear_trace();
    wx = 8'($urandom); wy = 8'($urandom);
    tick(1'b0, 1'b1, wx);
    tick(1'b0, 1'b1, wy);
    idle(4);
    parity_mode = 2'b01;
    tick(1'b0, 1'b0, ~wx);
    idle(50);
    st = find_first(tr_tx, 1'b0, 0);
    check("iso_first_slots", slots_of(st, 10), {6'b0, 1'b1, wx, 1'b0});
    d1 = find_first(tr_done, 1'b1, 0);
    d2 = (d1 < 0) ? -1 : find_first(tr_done, 1'b1, d1 + 1);
    check("iso_first_len", d1 - st, 20);
    check("iso_second_len", d2 - d1, 22);
    check("iso_second_parity", (d1 >= 0) ? tr_tx[d1 + CPB * 9] : 1'bx, ^wy);

    // Random traffic with occasional config changes and resets
    parity_mode = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        parity_mode = 2'($urandom_range(0, 3));
        two_stop    = 1'($urandom_range(0, 1));
      end
      tick($urandom_range(0, 399) == 0, $urandom_range(0, 2) != 0, 8'($urandom));
    end
    idle(80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
